l1_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate L1 word cache that sits directly upstream of the L2 cache. Accepts one CPU request at a time over a valid/ready handshake, serves read hits locally, and forwards read misses and all writes to L2 over a level req/ack handshake. Read-miss data returned by an L2 hit is filled into L1.

---
 rtl/cache_pkg.sv | 21 ++
 rtl/l1_tag_array.sv | 48 ++++
 rtl/l1_ctrl.sv | 157 +++++++++++++++
 tb/tb_l1_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the L1 word cache: FSM states, line layout, default width.
package cache_pkg;

  localparam int DEFAULT_WORD_SIZE = 32;
  // Line tags are carried at the widest possible tag width so any index size fits.
  localparam int LINE_TAG_MAX = DEFAULT_WORD_SIZE - 2;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    L2_REQ,
    RESP
  } l1_state_t;

  typedef struct packed {
    logic                         valid;
    logic [LINE_TAG_MAX-1:0]      tag;
    logic [DEFAULT_WORD_SIZE-1:0] data;
  } l1_line_t;

endpackage

// File: rtl/l1_tag_array.sv
// L1 line storage: combinational read port, synchronous write port, synchronous invalidate-all.
module l1_tag_array
  import cache_pkg::*;
#(
  parameter int WORD_SIZE   = DEFAULT_WORD_SIZE,
  parameter int INDEX_SIZE  = 3,
  parameter int L1_TAG_SIZE = WORD_SIZE - INDEX_SIZE - 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_SIZE-1:0]  rd_index,
  output l1_line_t               rd_line,
  input  logic                   wr_en,
  input  logic [INDEX_SIZE-1:0]  wr_index,
  input  logic [L1_TAG_SIZE-1:0] wr_tag,
  input  logic [WORD_SIZE-1:0]   wr_data
);

  localparam int LINES = 1 << INDEX_SIZE;

  logic [LINES-1:0]       valid_reg;
  logic [L1_TAG_SIZE-1:0] tag_mem  [LINES];
  logic [WORD_SIZE-1:0]   data_mem [LINES];

  // Only the valid bits are reset; tag and data contents are don't-care until filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
    end else if (wr_en) begin
      valid_reg[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  always_comb begin
    rd_line       = '0;
    rd_line.valid = valid_reg[rd_index];
    rd_line.tag   = LINE_TAG_MAX'(tag_mem[rd_index]);
    rd_line.data  = DEFAULT_WORD_SIZE'(data_mem[rd_index]);
  end

endmodule

// File: rtl/l1_ctrl.sv
// Direct-mapped write-through, no-write-allocate L1 word cache in front of L2.
// Optional hit/miss counters are enabled by defining L1_STATS_EN.
module l1_ctrl
  import cache_pkg::*;
#(
  parameter int WORD_SIZE   = DEFAULT_WORD_SIZE,
  parameter int INDEX_SIZE  = 3,
  parameter int L1_TAG_SIZE = WORD_SIZE - INDEX_SIZE - 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_valid,
  output logic                 cpu_ready,
  input  logic                 cpu_wr_en,
  input  logic [WORD_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic                 cpu_resp_valid,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  output logic                 cpu_hit,
  output logic                 l2_req,
  output logic                 l2_wr_en,
  output logic [WORD_SIZE-1:0] l2_addr,
  output logic [WORD_SIZE-1:0] l2_data,
  input  logic [WORD_SIZE-1:0] l2_data_in,
  input  logic                 l2_ack,
  input  logic                 l2_hit
`ifdef L1_STATS_EN
  ,
  output logic [15:0]          stat_hits,
  output logic [15:0]          stat_misses
`endif
);

  l1_state_t              state;
  logic [WORD_SIZE-1:0]   req_addr;
  logic [WORD_SIZE-1:0]   req_wdata;
  logic                   req_wr;

  logic [INDEX_SIZE-1:0]  req_index;
  logic [L1_TAG_SIZE-1:0] req_tag;
  l1_line_t               line;
  logic                   lookup_hit;
  logic                   arr_wr_en;
  logic [WORD_SIZE-1:0]   arr_wr_data;

  assign req_index  = req_addr[INDEX_SIZE+1:2];
  assign req_tag    = req_addr[WORD_SIZE-1:INDEX_SIZE+2];
  assign lookup_hit = line.valid && (line.tag == LINE_TAG_MAX'(req_tag));

  // Write hits update in place during LOOKUP; read fills land on the L2 ack.
  // Both cases leave the line valid with the captured tag, so one write port suffices.
  always_comb begin
    arr_wr_en   = 1'b0;
    arr_wr_data = req_wdata;
    if (state == LOOKUP && req_wr && lookup_hit) begin
      arr_wr_en = 1'b1;
    end else if (state == L2_REQ && l2_ack && !req_wr && l2_hit) begin
      arr_wr_en   = 1'b1;
      arr_wr_data = l2_data_in;
    end
  end

  l1_tag_array #(
    .WORD_SIZE  (WORD_SIZE),
    .INDEX_SIZE (INDEX_SIZE),
    .L1_TAG_SIZE(L1_TAG_SIZE)
  ) u_tag_array (
    .clk     (clk),
    .rst     (rst),
    .rd_index(req_index),
    .rd_line (line),
    .wr_en   (arr_wr_en),
    .wr_index(req_index),
    .wr_tag  (req_tag),
    .wr_data (arr_wr_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cpu_ready      <= 1'b1;
      cpu_resp_valid <= 1'b0;
      cpu_rdata      <= '0;
      cpu_hit        <= 1'b0;
      l2_req         <= 1'b0;
      l2_wr_en       <= 1'b0;
      l2_addr        <= '0;
      l2_data        <= '0;
      req_addr       <= '0;
      req_wdata      <= '0;
      req_wr         <= 1'b0;
`ifdef L1_STATS_EN
      stat_hits      <= '0;
      stat_misses    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cpu_valid && cpu_ready) begin
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            req_wr    <= cpu_wr_en;
            cpu_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!req_wr && lookup_hit) begin
            cpu_resp_valid <= 1'b1;
            cpu_rdata      <= WORD_SIZE'(line.data);
            cpu_hit        <= 1'b1;
            state          <= RESP;
`ifdef L1_STATS_EN
            if (stat_hits != 16'hFFFF) stat_hits <= stat_hits + 16'd1;
`endif
          end else begin
            l2_req   <= 1'b1;
            l2_wr_en <= req_wr;
            l2_addr  <= req_addr;
            l2_data  <= req_wdata;
            state    <= L2_REQ;
`ifdef L1_STATS_EN
            if (!req_wr && stat_misses != 16'hFFFF) stat_misses <= stat_misses + 16'd1;
`endif
          end
        end
        L2_REQ: begin
          if (l2_ack) begin
            l2_req         <= 1'b0;
            cpu_resp_valid <= 1'b1;
            state          <= RESP;
            if (req_wr) begin
              cpu_rdata <= '0;
              cpu_hit   <= 1'b1;
            end else if (l2_hit) begin
              cpu_rdata <= l2_data_in;
              cpu_hit   <= 1'b1;
            end else begin
              cpu_rdata <= '0;
              cpu_hit   <= 1'b0;
            end
          end
        end
        RESP: begin
          cpu_resp_valid <= 1'b0;
          cpu_ready      <= 1'b1;
          state          <= IDLE;
        end
        default: begin
          state     <= IDLE;
          cpu_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_ctrl.sv
// Directed plus randomized bench for l1_ctrl against a line-array reference model and a scripted L2.
module tb_l1_ctrl;

  localparam int W  = 32;
  localparam int IX = 3;
  localparam int NL = 1 << IX;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_valid, cpu_wr_en;
  logic          cpu_ready, cpu_resp_valid, cpu_hit;
  logic [W-1:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic          l2_req, l2_wr_en, l2_ack, l2_hit;
  logic [W-1:0]  l2_addr, l2_data, l2_data_in;
`ifdef L1_STATS_EN
  logic [15:0]   stat_hits, stat_misses;
`endif

  l1_ctrl #(.WORD_SIZE(W), .INDEX_SIZE(IX)) dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_wr_en(cpu_wr_en),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .l2_req(l2_req), .l2_wr_en(l2_wr_en), .l2_addr(l2_addr), .l2_data(l2_data),
    .l2_data_in(l2_data_in), .l2_ack(l2_ack), .l2_hit(l2_hit)
`ifdef L1_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what each line should hold, keyed by word index and tag.
  bit           mv [NL];
  logic [W-1:0] mt [NL];
  logic [W-1:0] md [NL];
  int           m_hits, m_misses;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) mv[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic txn(input logic wr, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                     input logic l2h, input logic [W-1:0] l2d, input int dly);
    int           idx, k, reqc, exp_lat;
    logic [W-1:0] tg, exp_data;
    logic         match, l1hit, exp_hit, saw, done;
    idx   = int'((addr >> 2) % NL);
    tg    = addr >> (IX + 2);
    match = mv[idx] && (mt[idx] == tg);
    l1hit = !wr && match;
    if (l1hit)      begin exp_data = md[idx]; exp_hit = 1'b1; end
    else if (wr)    begin exp_data = '0;      exp_hit = 1'b1; end
    else if (l2h)   begin exp_data = l2d;     exp_hit = 1'b1; end
    else            begin exp_data = '0;      exp_hit = 1'b0; end
    exp_lat = l1hit ? 2 : 3 + dly;
    if (wr && match) md[idx] = wdata;
    if (!wr && !match && l2h) begin mv[idx] = 1'b1; mt[idx] = tg; md[idx] = l2d; end
    if (!wr) begin if (l1hit) m_hits++; else m_misses++; end

    @(negedge clk);
    chk("idle_ready", {31'd0, cpu_ready}, 1);
    chk("idle_resp_low", {31'd0, cpu_resp_valid}, 0);
    cpu_valid = 1'b1; cpu_wr_en = wr; cpu_addr = addr; cpu_wdata = wdata;
    @(negedge clk);
    cpu_valid = 1'b0;
    k = 1; reqc = 0; saw = 1'b0; done = 1'b0;
    while (!done && k < 60) begin
      l2_ack = 1'b0;
      if (cpu_resp_valid) begin
        chk("latency", W'(k), W'(exp_lat));
        chk("rdata", cpu_rdata, exp_data);
        chk("hit", {31'd0, cpu_hit}, {31'd0, exp_hit});
        chk("l2_used", {31'd0, saw}, {31'd0, !l1hit});
        done = 1'b1;
      end else begin
        chk("busy_ready", {31'd0, cpu_ready}, 0);
        if (l2_req) begin
          saw = 1'b1;
          chk("l2_addr", l2_addr, addr);
          chk("l2_wr_en", {31'd0, l2_wr_en}, {31'd0, wr});
          if (wr) chk("l2_data", l2_data, wdata);
          if (reqc == dly) begin
            l2_ack = 1'b1; l2_hit = l2h; l2_data_in = l2d;
          end
          reqc++;
        end
        @(negedge clk);
        k++;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout addr=%h observed=no response expected=response", addr);
    end
    $display("txn %s addr=%h wdata=%h rdata=%h hit=%0d lat=%0d l2=%0d",
             wr ? "WR" : "RD", addr, wdata, cpu_rdata, cpu_hit, k, saw);
  endtask

  initial begin
    rst = 1'b1; cpu_valid = 1'b0; cpu_wr_en = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    l2_ack = 1'b0; l2_hit = 1'b0; l2_data_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, cpu_ready}, 1);
    chk("rst_resp_valid", {31'd0, cpu_resp_valid}, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_hit", {31'd0, cpu_hit}, 0);
    chk("rst_l2_req", {31'd0, l2_req}, 0);
    chk("rst_l2_wr_en", {31'd0, l2_wr_en}, 0);
    chk("rst_l2_addr", l2_addr, 0);
    chk("rst_l2_data", l2_data, 0);
    rst = 1'b0;

    // Directed: fill, hit, L2 miss without fill, write-through, conflict replacement.
    txn(1'b0, 32'h100, 32'h0, 1'b1, 32'hDEAD_BEEF, 0);
    txn(1'b0, 32'h100, 32'h0, 1'b1, 32'h0BAD_0BAD, 0);
    txn(1'b0, 32'h200, 32'h0, 1'b0, 32'h5555_5555, 1);
    txn(1'b0, 32'h200, 32'h0, 1'b0, 32'h6666_6666, 0);
    txn(1'b1, 32'h100, 32'h1234_5678, 1'b1, 32'h0, 2);
    txn(1'b0, 32'h100, 32'h0, 1'b1, 32'hFFFF_FFFF, 0);
    txn(1'b0, 32'h120, 32'h0, 1'b1, 32'hAAAA_0000, 0);
    txn(1'b0, 32'h120, 32'h0, 1'b1, 32'h0, 0);
    txn(1'b0, 32'h100, 32'h0, 1'b1, 32'h1111_2222, 3);
    txn(1'b1, 32'h340, 32'hCAFE_F00D, 1'b0, 32'h0, 0);
    txn(1'b0, 32'h340, 32'h0, 1'b0, 32'h0, 0);

    // Stalled L2 then reset mid-request: the request drops, nothing responds, lines are gone.
    @(negedge clk);
    cpu_valid = 1'b1; cpu_wr_en = 1'b0; cpu_addr = 32'h184; cpu_wdata = '0;
    @(negedge clk);
    cpu_valid = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("stall_l2_req", {31'd0, l2_req}, 1);
      chk("stall_l2_addr", l2_addr, 32'h184);
      chk("stall_ready", {31'd0, cpu_ready}, 0);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst_mid_l2_req", {31'd0, l2_req}, 0);
    chk("rst_mid_resp", {31'd0, cpu_resp_valid}, 0);
    chk("rst_mid_ready", {31'd0, cpu_ready}, 1);
    $display("txn RST mid-request addr=%h", 32'h184);
    txn(1'b0, 32'h100, 32'h0, 1'b1, 32'h7777_8888, 0);

    // Randomized traffic over a small address set so hits, conflicts and writes mix.
    for (int n = 0; n < 40; n++) begin
      logic         wr, l2h;
      logic [W-1:0] a;
      wr  = ($urandom_range(0, 3) == 0);
      a   = (W'($urandom_range(0, 3)) << (IX + 2)) | (W'($urandom_range(0, NL - 1)) << 2);
      l2h = 1'($urandom_range(0, 1));
      txn(wr, a, $urandom, l2h, $urandom, $urandom_range(0, 3));
    end

`ifdef L1_STATS_EN
    chk("stat_hits", {16'd0, stat_hits}, W'(m_hits));
    chk("stat_misses", {16'd0, stat_misses}, W'(m_misses));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
